// File: rtl/hilo_mult_sequencer.sv
// Multi-cycle radix-2 shift-add multiplier that owns the HI/LO register pair.
// It stalls EX when a multiply, an HI/LO read or an HI/LO write arrives while a multiply is running.
module hilo_mult_sequencer #(
    parameter int unsigned ITER = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        is_signed,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic        rd_hilo,
    input  logic        wr_hi,
    input  logic        wr_lo,
    input  logic [31:0] wdata,
    input  logic        flush,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done,
    output logic        stall_EX
);

    typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

    state_e      state_q, state_d;
    logic [31:0] mcand_q, mcand_d;
    logic [31:0] mplier_q, mplier_d;
    logic [63:0] acc_q, acc_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        neg_q, neg_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        done_q, done_d;

    logic [31:0] mag_a, mag_b;
    logic [32:0] sum;
    logic [63:0] product;

    always_comb begin
        mag_a   = (is_signed && op_a[31]) ? ~op_a + 32'd1 : op_a;
        mag_b   = (is_signed && op_b[31]) ? ~op_b + 32'd1 : op_b;
        // 33-bit sum keeps the carry so the right shift below never loses it
        sum     = {1'b0, acc_q[63:32]} + (mplier_q[0] ? {1'b0, mcand_q} : 33'd0);
        product = neg_q ? ~acc_q + 64'd1 : acc_q;
    end

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        neg_d    = neg_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start && !flush) begin
                    mcand_d  = mag_a;
                    mplier_d = mag_b;
                    neg_d    = is_signed & (op_a[31] ^ op_b[31]);
                    acc_d    = 64'd0;
                    cnt_d    = 6'd0;
                    state_d  = StRun;
                end else if (!start) begin
                    if (wr_hi) hi_d = wdata;
                    if (wr_lo) lo_d = wdata;
                end
            end
            StRun: begin
                if (flush) begin
                    state_d = StIdle;
                end else begin
                    acc_d    = {sum, acc_q[31:1]};
                    mplier_d = mplier_q >> 1;
                    cnt_d    = cnt_q + 6'd1;
                    if (cnt_q == 6'(ITER - 1)) state_d = StFix;
                end
            end
            StFix: begin
                state_d = StIdle;
                if (!flush) begin
                    hi_d   = product[63:32];
                    lo_d   = product[31:0];
                    done_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            mcand_q  <= 32'd0;
            mplier_q <= 32'd0;
            acc_q    <= 64'd0;
            cnt_q    <= 6'd0;
            neg_q    <= 1'b0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            neg_q    <= neg_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

    assign hi       = hi_q;
    assign lo       = lo_q;
    assign done     = done_q;
    assign busy     = (state_q != StIdle);
    assign stall_EX = busy & (start | rd_hilo | wr_hi | wr_lo);

endmodule

// File: tb/tb_hilo_mult_sequencer.sv
// Directed bench for hilo_mult_sequencer: a product table plus hand sequences for
// stalls, flush, HI/LO writes and asynchronous reset.
module tb_hilo_mult_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, is_signed, rd_hilo, wr_hi, wr_lo, flush;
    logic [31:0] op_a, op_b, wdata;
    logic [31:0] hi, lo;
    logic        busy, done, stall_EX;

    int n_pass  = 0;
    int n_total = 0;

    hilo_mult_sequencer #(.ITER(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .is_signed(is_signed),
        .op_a     (op_a),
        .op_b     (op_b),
        .rd_hilo  (rd_hilo),
        .wr_hi    (wr_hi),
        .wr_lo    (wr_lo),
        .wdata    (wdata),
        .flush    (flush),
        .hi       (hi),
        .lo       (lo),
        .busy     (busy),
        .done     (done),
        .stall_EX (stall_EX)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else n_pass++;
    endtask

    // Presents start for one edge (edge N), then waits on negedges for done.
    // Returns at the negedge of the done cycle; busy_cnt counts busy samples before it.
    task automatic run_mult(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                            output int busy_cnt, output logic got_done);
        @(negedge clk);
        start = 1'b1; is_signed = sgn; op_a = a; op_b = b;
        @(negedge clk);
        start = 1'b0;
        busy_cnt = 0;
        got_done = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (done) begin
                got_done = 1'b1;
                break;
            end
            if (busy) busy_cnt++;
            @(negedge clk);
        end
    endtask

    initial begin
        int   bc;
        logic gd;
        int   stall_cnt;

        vecs[0] = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[1] = '{1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        vecs[2] = '{1'b1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
        vecs[3] = '{1'b1, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1};
        vecs[4] = '{1'b1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001};
        vecs[5] = '{1'b0, 32'h8000_0000, 32'h0000_0002, 32'h0000_0001, 32'h0000_0000};
        vecs[6] = '{1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
        vecs[7] = '{1'b1, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000};
        vecs[8] = '{1'b0, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780};

        rst = 1'b0; start = 1'b0; is_signed = 1'b0; op_a = '0; op_b = '0;
        rd_hilo = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0; wdata = '0; flush = 1'b0;

        // Reset state
        #12;
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_stall", 64'(stall_EX), 64'd0);
        check("reset_hi", 64'(hi), 64'd0);
        check("reset_lo", 64'(lo), 64'd0);
        @(negedge clk);
        rst = 1'b1;

        // Product table
        for (int v = 0; v < 9; v++) begin
            run_mult(vecs[v].sgn, vecs[v].a, vecs[v].b, bc, gd);
            check($sformatf("vec%0d_done", v), 64'(gd), 64'd1);
            check($sformatf("vec%0d_busy_cycles", v), 64'(bc), 64'd33);
            check($sformatf("vec%0d_busy_at_done", v), 64'(busy), 64'd0);
            check($sformatf("vec%0d_hi", v), 64'(hi), 64'(vecs[v].exp_hi));
            check($sformatf("vec%0d_lo", v), 64'(lo), 64'(vecs[v].exp_lo));
            @(negedge clk);
            check($sformatf("vec%0d_done_pulse", v), 64'(done), 64'd0);
        end

        // Hazard stalls: mfhi/mflo held during 7x6, second start raised before edge N+5
        @(negedge clk);
        start = 1'b1; is_signed = 1'b0; op_a = 32'd7; op_b = 32'd6;
        @(negedge clk);                 // after edge N
        start = 1'b0;
        rd_hilo = 1'b1;
        stall_cnt = 0;
        for (int e = 0; e < 33; e++) begin
            if (e == 4) begin
                start = 1'b1; op_a = 32'd2; op_b = 32'd3;
            end
            if (stall_EX) stall_cnt++;
            @(negedge clk);
        end
        check("hazard_stall_cycles", 64'(stall_cnt), 64'd33);
        check("hazard_done", 64'(done), 64'd1);
        check("hazard_stall_in_done", 64'(stall_EX), 64'd0);
        check("hazard_lo", 64'(lo), 64'd42);
        @(negedge clk);
        check("hazard_second_accepted", 64'(busy), 64'd1);
        start = 1'b0;
        rd_hilo = 1'b0;
        gd = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (done) begin
                gd = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("hazard_second_done", 64'(gd), 64'd1);
        check("hazard_second_lo", 64'(lo), 64'd6);

        // HI/LO writes, one-edge latency
        @(negedge clk);
        wr_hi = 1'b1; wdata = 32'h1234_5678;
        @(negedge clk);
        check("write_hi", 64'(hi), 64'h1234_5678);
        wr_hi = 1'b0; wr_lo = 1'b1; wdata = 32'h9ABC_DEF0;
        @(negedge clk);
        wr_lo = 1'b0;
        check("write_lo", 64'(lo), 64'h9ABC_DEF0);
        check("write_lo_keeps_hi", 64'(hi), 64'h1234_5678);

        // Flush mid-RUN
        start = 1'b1; is_signed = 1'b0; op_a = 32'd3; op_b = 32'd5;
        @(negedge clk);
        start = 1'b0;
        for (int e = 0; e < 10; e++) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_busy", 64'(busy), 64'd0);
        gd = 1'b0;
        for (int e = 0; e < 30; e++) begin
            if (done) gd = 1'b1;
            @(negedge clk);
        end
        check("flush_no_done", 64'(gd), 64'd0);
        check("flush_hi", 64'(hi), 64'h1234_5678);
        check("flush_lo", 64'(lo), 64'h9ABC_DEF0);

        // Flush in IDLE blocks a simultaneous start
        flush = 1'b1; start = 1'b1;
        @(negedge clk);
        flush = 1'b0; start = 1'b0;
        check("idle_flush_ignores_start", 64'(busy), 64'd0);

        // Start and write in the same IDLE cycle: write dropped
        @(negedge clk);
        start = 1'b1; is_signed = 1'b0; op_a = 32'd1; op_b = 32'd1;
        wr_hi = 1'b1; wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        start = 1'b0; wr_hi = 1'b0;
        check("start_wins_busy", 64'(busy), 64'd1);
        check("start_wins_hi_kept", 64'(hi), 64'h1234_5678);
        gd = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (done) begin
                gd = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("start_wins_done", 64'(gd), 64'd1);
        check("start_wins_hi", 64'(hi), 64'd0);
        check("start_wins_lo", 64'(lo), 64'd1);

        // Preload HI so the reset check sees a real clear
        @(negedge clk);
        wr_hi = 1'b1; wr_lo = 1'b1; wdata = 32'hA5A5_5A5A;
        @(negedge clk);
        wr_hi = 1'b0; wr_lo = 1'b0;
        check("write_both_hi", 64'(hi), 64'hA5A5_5A5A);
        check("write_both_lo", 64'(lo), 64'hA5A5_5A5A);

        // Asynchronous reset mid-RUN
        start = 1'b1; is_signed = 1'b0; op_a = 32'hFFFF_FFFF; op_b = 32'hFFFF_FFFF;
        @(negedge clk);
        start = 1'b0;
        for (int e = 0; e < 10; e++) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("async_rst_busy", 64'(busy), 64'd0);
        check("async_rst_done", 64'(done), 64'd0);
        check("async_rst_hi", 64'(hi), 64'd0);
        check("async_rst_lo", 64'(lo), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        run_mult(1'b0, 32'd3, 32'd5, bc, gd);
        check("post_rst_done", 64'(gd), 64'd1);
        check("post_rst_busy_cycles", 64'(bc), 64'd33);
        check("post_rst_hi", 64'(hi), 64'd0);
        check("post_rst_lo", 64'(lo), 64'd15);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
